unicode_edge_wide_packer: RTL and testbench

Transmit-side packer that builds the 1024-bit wide bus and the 40-bit negative-range side field consumed by the wide-bus capture IP. It takes a narrow 32-bit valid/ready beat stream, assembles 32 beats (LSB-first) into one 1024-bit word, and presents the word with its side field on a registered valid/ready output. Short frames are zero-padded and flagged. It sits between the upstream stream source and the wide-bus consumer, in the main 100 MHz domain.

---
 rtl/unicode_edge_wide_packer_pkg.sv | 22 ++
 rtl/unicode_edge_wide_packer.sv | 93 +++++++++
 tb/tb_unicode_edge_wide_packer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/unicode_edge_wide_packer_pkg.sv
// Shared constants for the wide-bus transmit packer: default widths,
// side-field bounds and the two-state fill/hold machine encoding.
package unicode_edge_wide_packer_pkg;

   localparam int PK_DATA_W = 32;
   localparam int PK_WIDE_W = 1024;

   localparam int SIDE_HI = 31;
   localparam int SIDE_LO = -8;
   localparam int SIDE_W  = SIDE_HI - SIDE_LO + 1;

   typedef enum logic [0:0] {
      FILL = 1'b0,
      HOLD = 1'b1
   } pk_state_e;

   localparam logic [0:0] ST_FILL = FILL;
   localparam logic [0:0] ST_HOLD = HOLD;

   typedef logic [SIDE_W-1:0] side_flat_t;

endpackage

// File: rtl/unicode_edge_wide_packer.sv
// Packs 32-bit beats LSB-first into a 1024-bit word with a 40-bit side field;
// short frames are zero-padded and flagged, with a saturating short-frame count.
module unicode_edge_wide_packer
   import unicode_edge_wide_packer_pkg::*;
#(
   parameter int DATA_W = PK_DATA_W,
   parameter int WIDE_W = PK_WIDE_W,
   parameter int CNT_W  = 8
) (
   input  logic                       clk_main_domain_100mhz_primary_oscillator,
   input  logic                       reset_system_wide_asynchronous_active_low_synchronized,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [DATA_W-1:0]          s_data,
   input  logic                       s_last,
   input  logic [SIDE_HI:SIDE_LO]     s_side,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [WIDE_W-1:0]          m_wide,
   output logic [SIDE_HI:SIDE_LO]     m_side,
   output logic                       m_short,
   output logic [CNT_W-1:0]           short_count
);

   localparam int BEATS = WIDE_W / DATA_W;
   localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [0:0]       state;
   logic [IDX_W-1:0] beat_idx;
   logic             beat_fire;
   logic             frame_end;
   logic             out_fire;

   // s_ready depends on registered state only, never on m_ready or s_valid
   assign s_ready   = (state == ST_FILL);
   assign beat_fire = s_valid && s_ready;
   assign frame_end = beat_fire && (s_last || (beat_idx == LAST_IDX));
   assign out_fire  = m_valid && m_ready;

   always_ff @(posedge clk_main_domain_100mhz_primary_oscillator
               or negedge reset_system_wide_asynchronous_active_low_synchronized) begin
      if (!reset_system_wide_asynchronous_active_low_synchronized) begin
         state       <= ST_FILL;
         beat_idx    <= '0;
         m_valid     <= 1'b0;
         m_wide      <= '0;
         m_side      <= '0;
         m_short     <= 1'b0;
         short_count <= '0;
      end else begin
         case (state)
            ST_FILL: begin
               if (beat_fire) begin
                  m_wide[DATA_W*beat_idx +: DATA_W] <= s_data;
                  if (beat_idx == '0) begin
                     m_side <= s_side;
                  end
                  if (frame_end) begin
                     state   <= ST_HOLD;
                     m_valid <= 1'b1;
                     m_short <= (beat_idx != LAST_IDX);
                  end else begin
                     beat_idx <= beat_idx + 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               // word is cleared here so unwritten lanes of the next frame read zero
               if (out_fire) begin
                  if (m_short) begin
                     short_count <= sat_inc(short_count);
                  end
                  state    <= ST_FILL;
                  m_valid  <= 1'b0;
                  m_short  <= 1'b0;
                  beat_idx <= '0;
                  m_wide   <= '0;
               end
            end
            default: begin
               state   <= ST_FILL;
               m_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_unicode_edge_wide_packer.sv
// Scoreboard bench for unicode_edge_wide_packer: directed frames push expected
// words; a negedge monitor pops and compares on every output handshake.
`timescale 1ns/1ps
module tb_unicode_edge_wide_packer;
   import unicode_edge_wide_packer_pkg::*;

   localparam int DW = 32;
   localparam int WW = 1024;
   localparam int CW = 8;
   localparam int NB = WW / DW;

   typedef struct {
      logic [WW-1:0]          wide;
      logic [SIDE_HI:SIDE_LO] side;
      logic                   short_f;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   s_valid = 1'b0;
   logic                   s_ready;
   logic [DW-1:0]          s_data = '0;
   logic                   s_last = 1'b0;
   logic [SIDE_HI:SIDE_LO] s_side = '0;
   logic                   m_valid;
   logic                   m_ready = 1'b0;
   logic [WW-1:0]          m_wide;
   logic [SIDE_HI:SIDE_LO] m_side;
   logic                   m_short;
   logic [CW-1:0]          short_count;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t exp_q[$];
   int   hs_cyc[$];
   exp_t mon_e;

   unicode_edge_wide_packer #(.DATA_W(DW), .WIDE_W(WW), .CNT_W(CW)) dut (
      .clk_main_domain_100mhz_primary_oscillator(clk),
      .reset_system_wide_asynchronous_active_low_synchronized(rst_n),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .s_data(s_data),
      .s_last(s_last),
      .s_side(s_side),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .m_wide(m_wide),
      .m_side(m_side),
      .m_short(m_short),
      .short_count(short_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: the handshake completes at the next rising edge when both are high here.
   always @(negedge clk) begin
      if (rst_n && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word actual=%0h required=none", m_wide[DW-1:0]);
         end else begin
            mon_e = exp_q.pop_front();
            checks++;
            if (m_wide !== mon_e.wide) begin
               int bad;
               bad = 0;
               for (int l = 0; l < NB; l++) begin
                  if (m_wide[DW*l +: DW] !== mon_e.wide[DW*l +: DW]) begin
                     bad = l;
                     break;
                  end
               end
               errors++;
               $display("FAIL word lane %0d actual=%0h required=%0h", bad,
                        m_wide[DW*bad +: DW], mon_e.wide[DW*bad +: DW]);
            end
            chk("word_side", 64'(m_side), 64'(mon_e.side));
            chk("word_short", 64'(m_short), 64'(mon_e.short_f));
            hs_cyc.push_back(cyc);
         end
      end
   end

   task automatic send_beat(input logic [DW-1:0] d, input logic [SIDE_HI:SIDE_LO] sd, input logic l);
      int guard;
      guard = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_side  = sd;
      s_last  = l;
      while (!s_ready && guard < 200) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (guard >= 200) begin
         checks++;
         errors++;
         $display("FAIL s_ready_timeout actual=0 required=1");
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_frame(input int n, input logic [DW-1:0] base,
                             input logic [SIDE_HI:SIDE_LO] side, input bit use_last,
                             output exp_t eo);
      eo.wide    = '0;
      eo.side    = side;
      eo.short_f = (n < NB);
      for (int k = 0; k < n; k++) eo.wide[DW*k +: DW] = base + DW'(k);
      exp_q.push_back(eo);
      for (int k = 0; k < n; k++) begin
         send_beat(base + DW'(k),
                   (k == 0) ? side : (40'hFF_1234_5678 ^ 40'(k)),
                   use_last && (k == n - 1));
      end
   endtask

   initial begin
      exp_t e;
      int   b;
      int   guard;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_s_ready", 64'(s_ready), 64'd1);
      chk("rst_m_short", 64'(m_short), 64'd0);
      chk("rst_short_count", 64'(short_count), 64'd0);
      chk("rst_m_side", 64'(m_side), 64'd0);
      chk("rst_m_wide_zero", 64'(m_wide == '0), 64'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full frame, s_last on beat 31
      m_ready = 1'b1;
      send_frame(NB, 32'd1, 40'hA5_0000_00F0, 1'b1, e);
      chk("full_valid_latency", 64'(m_valid), 64'd1);
      chk("full_s_ready_hold", 64'(s_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("full_valid_one_cycle", 64'(m_valid), 64'd0);
      chk("full_s_ready_after", 64'(s_ready), 64'd1);

      // Short frame of 3 beats
      send_frame(3, 32'hDEAD_0001, 40'h01_0203_0405, 1'b1, e);
      chk("short_flag", 64'(m_short), 64'd1);
      @(posedge clk);
      #1;
      chk("short_count_1", 64'(short_count), 64'd1);
      chk("short_cleared", 64'(m_short), 64'd0);

      // Backpressure on a 5-beat short frame, with a pending beat held upstream
      m_ready = 1'b0;
      send_frame(5, 32'hC0DE_0000, 40'h12_3456_789A, 1'b1, e);
      s_valid = 1'b1;
      s_data  = 32'h7777_0001;
      s_side  = 40'h0F_0E0D_0C0B;
      s_last  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("bp_wide_stable", 64'(m_wide == e.wide), 64'd1);
         chk("bp_side_stable", 64'(m_side), 64'(e.side));
         chk("bp_s_ready", 64'(s_ready), 64'd0);
         chk("bp_m_valid", 64'(m_valid), 64'd1);
      end
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_s_ready_after_hs", 64'(s_ready), 64'd1);
      chk("bp_m_valid_after_hs", 64'(m_valid), 64'd0);
      e.wide    = '0;
      e.wide[DW-1:0] = 32'h7777_0001;
      e.side    = 40'h0F_0E0D_0C0B;
      e.short_f = 1'b1;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      @(posedge clk);
      #1;

      // Back-to-back full frames; frames 1 and 3 close without s_last
      b = hs_cyc.size();
      send_frame(NB, 32'h1000_0000, 40'h00_0000_0011, 1'b1, e);
      send_frame(NB, 32'h2000_0000, 40'h80_0000_0022, 1'b0, e);
      send_frame(NB, 32'h3000_0000, 40'h7F_FFFF_FF33, 1'b1, e);
      send_frame(NB, 32'h4000_0000, 40'hC3_5A5A_0044, 1'b0, e);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("b2b_frames_seen", 64'(hs_cyc.size() - b), 64'd4);
      if (hs_cyc.size() - b == 4) begin
         for (int i = 1; i < 4; i++) chk("b2b_frame_period", 64'(hs_cyc[b+i] - hs_cyc[b+i-1]), 64'd33);
      end

      // Reset in the middle of a frame after 17 beats
      for (int k = 0; k < 17; k++) send_beat(32'hBAD0_0000 + 32'(k), 40'hEE_EEEE_EEEE, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("async_rst_wide", 64'(m_wide == '0), 64'd1);
      chk("async_rst_side", 64'(m_side), 64'd0);
      chk("async_rst_short_count", 64'(short_count), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_frame(NB, 32'h0000_0100, 40'h5A_0000_0001, 1'b1, e);
      @(posedge clk);
      #1;
      chk("post_rst_short_count", 64'(short_count), 64'd0);

      // Saturation of the short-frame counter
      for (int i = 0; i < 300; i++) begin
         send_frame(1, 32'h5000_0000 + 32'(i), 40'h33_0000_0000 ^ 40'(i), 1'b1, e);
         if (i == 254) begin
            @(posedge clk);
            #1;
            chk("short_count_at_255", 64'(short_count), 64'd255);
         end
      end
      @(posedge clk);
      #1;
      chk("short_count_saturated", 64'(short_count), 64'd255);

      guard = 0;
      while (exp_q.size() != 0 && guard < 100) begin
         @(posedge clk);
         #1;
         guard++;
      end
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
